// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC shift scheduler: state encoding, default widths
// and operand-select constants.
package cordic_pkg;

  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned IW_DEF    = 5;

  localparam logic SEL_X = 1'b0;
  localparam logic SEL_Y = 1'b1;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StShx  = 3'd1,
    StShy  = 3'd2,
    StUpd  = 3'd3,
    StFin  = 3'd4
  } state_e;

endpackage

// File: rtl/cordic_shift_fsm.sv
// Sequencing core: state register, iteration counter, latched command and the
// state-decoded control outputs for the shared shift unit.
module cordic_shift_fsm
  import cordic_pkg::*;
#(
  parameter int unsigned IW = IW_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic [IW-1:0] i_n_iter,
  input  logic          i_dir,
  output logic [IW-1:0] o_iter,
  output logic          o_dir,
  output logic          o_sh_sel,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_upd_en,
  output logic          o_cap_x,
  output logic          o_cap_y
);

  state_e        r_state, w_state_d;
  logic [IW-1:0] r_iter, w_iter_d;
  logic [IW-1:0] r_n_iter, w_n_iter_d;
  logic          r_dir, w_dir_d;
  logic          w_last;
  logic          w_abort_act;

  assign w_last      = (r_iter == (r_n_iter - IW'(1)));
  assign w_abort_act = i_abort && (r_state != StIdle);

  always_comb begin
    w_state_d  = r_state;
    w_iter_d   = r_iter;
    w_n_iter_d = r_n_iter;
    w_dir_d    = r_dir;
    if (w_abort_act) begin
      w_state_d = StIdle;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            w_n_iter_d = i_n_iter;
            w_dir_d    = i_dir;
            w_iter_d   = '0;
            w_state_d  = (i_n_iter == '0) ? StFin : StShx;
          end
        end
        StShx: w_state_d = StShy;
        StShy: w_state_d = StUpd;
        StUpd: begin
          if (w_last) begin
            w_state_d = StFin;
          end else begin
            w_iter_d  = r_iter + IW'(1);
            w_state_d = StShx;
          end
        end
        StFin:   w_state_d = StIdle;
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= StIdle;
      r_iter   <= '0;
      r_n_iter <= '0;
      r_dir    <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_iter   <= w_iter_d;
      r_n_iter <= w_n_iter_d;
      r_dir    <= w_dir_d;
    end
  end

  // Outputs decode from state only; abort gates just the internal capture strobes.
  assign o_iter   = r_iter;
  assign o_dir    = r_dir;
  assign o_sh_sel = (r_state == StShy) ? SEL_Y : SEL_X;
  assign o_busy   = (r_state != StIdle);
  assign o_done   = (r_state == StFin);
  assign o_upd_en = (r_state == StUpd);
  assign o_cap_x  = (r_state == StShx) && !i_abort;
  assign o_cap_y  = (r_state == StShy) && !i_abort;

endmodule

// File: rtl/cordic_shift_sched.sv
// CORDIC shift scheduler top: time-multiplexes one external shifter between the X
// and Y operands and registers both shifted results for the datapath update.
module cordic_shift_sched
  import cordic_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned IW    = IW_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [IW-1:0]    i_n_iter,
  input  logic             i_dir,
  input  logic [WIDTH-1:0] i_sh_result,
  output logic             o_sh_sel,
  output logic             o_sh_rightleft,
  output logic [IW-1:0]    o_sh_amount,
  output logic [WIDTH-1:0] o_x_sh,
  output logic [WIDTH-1:0] o_y_sh,
  output logic             o_upd_en,
  output logic [IW-1:0]    o_iter,
  output logic             o_busy,
  output logic             o_done
);

  logic [IW-1:0]    w_iter;
  logic             w_dir;
  logic             w_cap_x;
  logic             w_cap_y;
  logic [WIDTH-1:0] r_x_sh;
  logic [WIDTH-1:0] r_y_sh;

  cordic_shift_fsm #(
    .IW (IW)
  ) u_fsm (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_start  (i_start),
    .i_abort  (i_abort),
    .i_n_iter (i_n_iter),
    .i_dir    (i_dir),
    .o_iter   (w_iter),
    .o_dir    (w_dir),
    .o_sh_sel (o_sh_sel),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_upd_en (o_upd_en),
    .o_cap_x  (w_cap_x),
    .o_cap_y  (w_cap_y)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x_sh <= '0;
      r_y_sh <= '0;
    end else begin
      if (w_cap_x) r_x_sh <= i_sh_result;
      if (w_cap_y) r_y_sh <= i_sh_result;
    end
  end

  assign o_sh_rightleft = w_dir;
  assign o_sh_amount    = w_iter;
  assign o_iter         = w_iter;
  assign o_x_sh         = r_x_sh;
  assign o_y_sh         = r_y_sh;

endmodule

// File: tb/tb_cordic_shift_sched.sv
// Directed bench for cordic_shift_sched with a behavioural model of the external shifter.
module tb_cordic_shift_sched;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [4:0]  n_iter;
  logic        dir;
  logic [31:0] sh_result;
  logic        sh_sel;
  logic        sh_rightleft;
  logic [4:0]  sh_amount;
  logic [31:0] x_sh;
  logic [31:0] y_sh;
  logic        upd_en;
  logic [4:0]  iter;
  logic        busy;
  logic        done;

  logic [31:0] x_op;
  logic [31:0] y_op;
  logic [31:0] last_x;
  logic [31:0] last_y;
  int          n_checks;
  int          n_errors;

  cordic_shift_sched dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_start        (start),
    .i_abort        (abort),
    .i_n_iter       (n_iter),
    .i_dir          (dir),
    .i_sh_result    (sh_result),
    .o_sh_sel       (sh_sel),
    .o_sh_rightleft (sh_rightleft),
    .o_sh_amount    (sh_amount),
    .o_x_sh         (x_sh),
    .o_y_sh         (y_sh),
    .o_upd_en       (upd_en),
    .o_iter         (iter),
    .o_busy         (busy),
    .o_done         (done)
  );

  // dir=1 shifts left, dir=0 shifts right.
  always_comb begin
    sh_result = '0;
    if (sh_sel) sh_result = sh_rightleft ? (y_op << sh_amount) : (y_op >> sh_amount);
    else        sh_result = sh_rightleft ? (x_op << sh_amount) : (x_op >> sh_amount);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a sequence and checks every cycle up to two cycles past done.
  task automatic run_seq(input string name, input logic [4:0] n, input logic d,
                         input int repulse_at, output logic [31:0] lx, output logic [31:0] ly);
    int   upd_cnt;
    int   lat;
    int   nn;
    logic e_upd;
    logic e_sel;
    int   e_iter;
    upd_cnt = 0;
    nn      = int'(n);
    lat     = (nn == 0) ? 1 : 3 * nn + 1;
    lx      = '0;
    ly      = '0;
    n_iter  = n;
    dir     = d;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    for (int k = 1; k <= lat + 2; k++) begin
      e_upd  = (nn != 0) && (k <= 3 * nn) && (k % 3 == 0);
      e_sel  = (nn != 0) && (k <= 3 * nn) && (k % 3 == 2);
      e_iter = (nn == 0) ? 0 : ((k <= 3 * nn) ? (k - 1) / 3 : nn - 1);
      check($sformatf("%s.upd_en@%0d", name, k), 64'(upd_en), 64'(e_upd));
      check($sformatf("%s.done@%0d", name, k), 64'(done), 64'(k == lat));
      check($sformatf("%s.busy@%0d", name, k), 64'(busy), 64'(k <= lat));
      check($sformatf("%s.sh_sel@%0d", name, k), 64'(sh_sel), 64'(e_sel));
      check($sformatf("%s.iter@%0d", name, k), 64'(iter), 64'(e_iter));
      check($sformatf("%s.sh_amount@%0d", name, k), 64'(sh_amount), 64'(e_iter));
      check($sformatf("%s.rightleft@%0d", name, k), 64'(sh_rightleft), 64'(d));
      if (upd_en) upd_cnt++;
      if (nn != 0 && k == 3 * nn) begin
        lx = x_sh;
        ly = y_sh;
      end
      if (k == repulse_at) begin
        start  = 1'b1;
        n_iter = 5'd7;
        dir    = ~d;
      end
      tick();
      start = 1'b0;
    end
    check({name, ".upd_count"}, 64'(upd_cnt), 64'(nn));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    n_iter   = '0;
    dir      = 1'b0;
    x_op     = 32'h12345678;
    y_op     = 32'h0000FFFF;
    #12;
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.done", 64'(done), 64'd0);
    check("rst.upd_en", 64'(upd_en), 64'd0);
    check("rst.iter", 64'(iter), 64'd0);
    check("rst.x_sh", 64'(x_sh), 64'd0);
    check("rst.y_sh", 64'(y_sh), 64'd0);
    #10;
    rst_n = 1'b1;

    // First start right after release, with a start re-pulse mid-run.
    run_seq("n4", 5'd4, 1'b0, 5, last_x, last_y);
    check("n4.x_sh_it3", 64'(last_x), 64'h02468ACF);
    check("n4.y_sh_it3", 64'(last_y), 64'h00001FFF);

    run_seq("n0", 5'd0, 1'b0, 0, last_x, last_y);

    // Abort in SHY of iteration 2.
    n_iter = 5'd4;
    dir    = 1'b0;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    repeat (7) tick();
    check("abort.pre_sel", 64'(sh_sel), 64'd1);
    check("abort.pre_iter", 64'(iter), 64'd2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort.busy", 64'(busy), 64'd0);
    check("abort.done", 64'(done), 64'd0);
    check("abort.upd_en", 64'(upd_en), 64'd0);
    check("abort.iter", 64'(iter), 64'd2);
    check("abort.x_sh", 64'(x_sh), 64'h048D159E);
    check("abort.y_sh", 64'(y_sh), 64'h00007FFF);
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("abort.idle_done@%0d", k), 64'(done), 64'd0);
      check($sformatf("abort.idle_busy@%0d", k), 64'(busy), 64'd0);
    end
    run_seq("post_abort", 5'd1, 1'b0, 0, last_x, last_y);
    check("post_abort.x_sh", 64'(last_x), 64'h12345678);

    // start and abort together in IDLE: start wins.
    n_iter = 5'd1;
    start  = 1'b1;
    abort  = 1'b1;
    tick();
    start  = 1'b0;
    abort  = 1'b0;
    check("sa.busy", 64'(busy), 64'd1);
    check("sa.iter", 64'(iter), 64'd0);
    tick();
    tick();
    check("sa.upd_en", 64'(upd_en), 64'd1);
    tick();
    check("sa.done", 64'(done), 64'd1);
    tick();
    check("sa.idle", 64'(busy), 64'd0);

    // Reset during UPD of iteration 1.
    n_iter = 5'd4;
    dir    = 1'b1;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    repeat (5) tick();
    check("rmid.pre_upd", 64'(upd_en), 64'd1);
    check("rmid.pre_iter", 64'(iter), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rmid.busy", 64'(busy), 64'd0);
    check("rmid.done", 64'(done), 64'd0);
    check("rmid.upd_en", 64'(upd_en), 64'd0);
    check("rmid.sh_sel", 64'(sh_sel), 64'd0);
    check("rmid.iter", 64'(iter), 64'd0);
    check("rmid.x_sh", 64'(x_sh), 64'd0);
    check("rmid.y_sh", 64'(y_sh), 64'd0);
    check("rmid.rightleft", 64'(sh_rightleft), 64'd0);
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      tick();
      check($sformatf("rmid.no_done@%0d", k), 64'(done), 64'd0);
    end
    run_seq("rmid_n1", 5'd1, 1'b0, 0, last_x, last_y);

    // Maximum iteration count, left shifts.
    run_seq("n31", 5'd31, 1'b1, 0, last_x, last_y);
    check("n31.x_sh_last", 64'(last_x), 64'h00000000);
    check("n31.y_sh_last", 64'(last_y), 64'hC0000000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
